// File: rtl/bus_arbiter_3req.sv
// ----------------------------------------------------------------------------
// bus_arbiter_3req
//
// Round-robin arbiter and sequencer for a 3-input shared-bus multiplexer.
// One requester is granted at a time. The arbiter drives the external mux
// select code and captures the selected word into a single-entry output
// register with a valid/ready handshake. Each grant is limited to MAX_HOLD
// beats, so a requester that keeps its request high cannot starve the others.
//
// Parameters
//   DATA_WIDTH : width of bus words
//   MAX_HOLD   : maximum beats accepted per grant (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [2:0] per-requester request
//   ack        out  [2:0] one-hot, requester's word accepted this cycle
//   sel        out  [2:0] mux select (0/1/2 = requester, 3'b011 = idle)
//   mux_out    in   [DATA_WIDTH-1:0] output of the external mux
//   out_data   out  [DATA_WIDTH-1:0] registered accepted word
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   downstream accepts out_data this cycle
//   busy       out  high while a grant is active
// ----------------------------------------------------------------------------
module bus_arbiter_3req #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   output logic [2:0]            ack,
   output logic [2:0]            sel,
   input  logic [DATA_WIDTH-1:0] mux_out,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                  state_reg, state_next;
   logic [1:0]              ptr_reg, ptr_next;
   logic [1:0]              gnt_id_reg, gnt_id_next;
   logic [3:0]              beat_cnt_reg, beat_cnt_next;
   logic                    out_valid_reg;
   logic [DATA_WIDTH-1:0]   out_data_reg;

   logic                    fire;
   logic                    req_gnt;
   logic [1:0]              winner;
   logic [1:0]              search_idx [3];
   logic [2:0]              search_hit;

   // (a + b) mod 3 for requester indices 0..2
   function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 3'd3)
         s = s - 3'd3;
      return s[1:0];
   endfunction

   // Request bit of a given requester index; index 3 never requests
   function automatic logic req_bit(input logic [2:0] r, input logic [1:0] idx);
      logic b;
      case (idx)
         2'd0:    b = r[0];
         2'd1:    b = r[1];
         2'd2:    b = r[2];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   // Search order starts at ptr and wraps around the three requesters
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_search
         assign search_idx[gi] = add_mod3(ptr_reg, 2'(gi));
         assign search_hit[gi] = req_bit(req, search_idx[gi]);
      end
   endgenerate

   always_comb begin
      winner = search_idx[2];
      if (search_hit[0])
         winner = search_idx[0];
      else if (search_hit[1])
         winner = search_idx[1];
   end

   assign req_gnt = req_bit(req, gnt_id_reg);

   // Next-state logic and combinational outputs
   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      gnt_id_next   = gnt_id_reg;
      beat_cnt_next = beat_cnt_reg;
      sel           = 3'b011;
      busy          = 1'b0;
      fire          = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               state_next    = GRANT;
               gnt_id_next   = winner;
               beat_cnt_next = 4'd0;
            end
         end
         GRANT: begin
            sel  = {1'b0, gnt_id_reg};
            busy = 1'b1;
            // A beat moves only when the output register is empty or is
            // being drained in the same cycle.
            fire = req_gnt & (~out_valid_reg | out_ready);
            if (fire)
               beat_cnt_next = beat_cnt_reg + 4'd1;
            if (!req_gnt || (fire && (beat_cnt_reg + 4'd1 == MAX_HOLD_C))) begin
               state_next = IDLE;
               ptr_next   = add_mod3(gnt_id_reg, 2'd1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ack
         assign ack[gi] = fire & (gnt_id_reg == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= 2'd0;
         gnt_id_reg   <= 2'd0;
         beat_cnt_reg <= 4'd0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         gnt_id_reg   <= gnt_id_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   // Single-entry output stage; a simultaneous fire and drain keeps
   // out_valid high and replaces the word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (fire) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= mux_out;
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;

endmodule
